// File: rtl/mux_nx1_skid_if.sv
// Handshake and data bundle for the N-to-1 selector with skid stage.
interface mux_nx1_skid_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
);
  logic [N*WIDTH-1:0] mux_in;
  logic [SEL_W-1:0]   mux_ctrl;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [WIDTH-1:0]   choice;
  logic [SEL_W-1:0]   choice_sel;
  logic               sel_err;
  logic               out_valid;
  logic               out_ready;

  // Source/sink side: drives channels and select, consumes the head entry
  modport master (
    output mux_in, mux_ctrl, in_valid, flush, out_ready,
    input  in_ready, choice, choice_sel, sel_err, out_valid
  );

  // Selector side
  modport slave (
    input  mux_in, mux_ctrl, in_valid, flush, out_ready,
    output in_ready, choice, choice_sel, sel_err, out_valid
  );
endinterface

// File: rtl/mux_nx1_skid.sv
// N-input selector feeding a registered main+skid pair with valid/ready handshake.
// in_ready and out_valid are registered copies of the next-state decode, so
// neither out_ready nor the data inputs reach any output combinationally.
module mux_nx1_skid #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
) (
  input logic            clk,
  input logic            rst_n,
  mux_nx1_skid_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  entry_t r_main;
  entry_t r_skid;
  entry_t w_new;
  logic   r_in_ready;
  logic   r_out_valid;
  logic   w_accept;
  logic   w_consume;
  logic   w_load_main;
  logic   w_main_from_skid;
  logic   w_load_skid;

  assign w_accept  = bus.in_valid & r_in_ready;
  assign w_consume = r_out_valid & bus.out_ready;

  // Build the entry for the channel named by mux_ctrl; out-of-range gives zero data
  always_comb begin
    w_new      = '0;
    w_new.sel  = bus.mux_ctrl;
    w_new.err  = (32'(bus.mux_ctrl) >= N);
    for (int k = 0; k < int'(N); k++) begin
      if (bus.mux_ctrl == SEL_W'(k)) begin
        w_new.data = bus.mux_in[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and register-load decode; flush wins over every transfer
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (bus.flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_load_main = 1'b1;
            w_state_nxt = S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_consume) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            w_load_skid = 1'b1;
            w_state_nxt = S_FULL;
          end else if (w_consume) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_consume) begin
            w_main_from_skid = 1'b1;
            w_state_nxt      = S_ONE;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // State register with registered handshake flags derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  // Main and skid storage; unloaded registers hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main) begin
        r_main <= w_new;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_new;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.choice     = r_main.data;
  assign bus.choice_sel = r_main.sel;
  assign bus.sel_err    = r_main.err;

endmodule

// File: tb/tb_mux_nx1_skid.sv
// Directed bench for mux_nx1_skid: a 4-channel instance plus a 3-channel one
// for out-of-range selects.
module tb_mux_nx1_skid;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mux_nx1_skid_if #(.WIDTH(16), .N(4), .SEL_W(2)) bus4 ();
  mux_nx1_skid_if #(.WIDTH(16), .N(3), .SEL_W(2)) bus3 ();

  mux_nx1_skid #(.WIDTH(16), .N(4), .SEL_W(2)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  mux_nx1_skid #(.WIDTH(16), .N(3), .SEL_W(2)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  // Advance one edge; sample and drive 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus4.in_valid  = 1'b0;
    bus4.mux_ctrl  = 2'd0;
    bus4.flush     = 1'b0;
    bus4.out_ready = 1'b0;
    bus3.in_valid  = 1'b0;
    bus3.mux_ctrl  = 2'd0;
    bus3.flush     = 1'b0;
    bus3.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++;
      if (bus4.in_ready !== 1'b1) $display("FAIL reset_in_ready cyc %0d got %b exp 1", i, bus4.in_ready);
      else n_pass++;
      n_total++;
      if (bus4.out_valid !== 1'b0) $display("FAIL reset_out_valid cyc %0d got %b exp 0", i, bus4.out_valid);
      else n_pass++;
      n_total++;
      if (bus4.choice !== 16'h0000) $display("FAIL reset_choice cyc %0d got %h exp 0000", i, bus4.choice);
      else n_pass++;
    end
  endtask

  task automatic test_streaming();
    logic [15:0] exp_data [4];
    exp_data[0] = 16'hAAAA;
    exp_data[1] = 16'hBBBB;
    exp_data[2] = 16'hCCCC;
    exp_data[3] = 16'hDDDD;
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 1'b1;
    bus4.mux_ctrl  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (bus4.out_valid !== 1'b1 || bus4.choice !== exp_data[i] || bus4.choice_sel !== 2'(i))
        $display("FAIL stream_%0d got v=%b d=%h s=%0d exp v=1 d=%h s=%0d",
                 i, bus4.out_valid, bus4.choice, bus4.choice_sel, exp_data[i], i);
      else n_pass++;
      n_total++;
      if (bus4.in_ready !== 1'b1) $display("FAIL stream_ready_%0d got %b exp 1", i, bus4.in_ready);
      else n_pass++;
      if (i < 3) bus4.mux_ctrl = 2'(i + 1);
      else bus4.in_valid = 1'b0;
    end
    tick();
    n_total++;
    if (bus4.out_valid !== 1'b0) $display("FAIL stream_drain got %b exp 0", bus4.out_valid);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_backpressure();
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 1'b1;
    bus4.mux_ctrl  = 2'd1;
    tick();
    n_total++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b1 || bus4.choice !== 16'hBBBB)
      $display("FAIL bp_one got r=%b v=%b d=%h exp r=1 v=1 d=bbbb", bus4.in_ready, bus4.out_valid, bus4.choice);
    else n_pass++;
    bus4.mux_ctrl = 2'd2;
    tick();
    n_total++;
    if (bus4.in_ready !== 1'b0 || bus4.out_valid !== 1'b1 || bus4.choice !== 16'hBBBB)
      $display("FAIL bp_full got r=%b v=%b d=%h exp r=0 v=1 d=bbbb", bus4.in_ready, bus4.out_valid, bus4.choice);
    else n_pass++;
    // Offer stays up in FULL but must not be taken
    bus4.mux_ctrl = 2'd3;
    tick();
    n_total++;
    if (bus4.in_ready !== 1'b0 || bus4.choice !== 16'hBBBB)
      $display("FAIL bp_hold got r=%b d=%h exp r=0 d=bbbb", bus4.in_ready, bus4.choice);
    else n_pass++;
    bus4.out_ready = 1'b1;
    tick();
    n_total++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b1 || bus4.choice !== 16'hCCCC || bus4.choice_sel !== 2'd2)
      $display("FAIL bp_release got r=%b v=%b d=%h s=%0d exp r=1 v=1 d=cccc s=2",
               bus4.in_ready, bus4.out_valid, bus4.choice, bus4.choice_sel);
    else n_pass++;
    bus4.in_valid = 1'b0;
    tick();
    n_total++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1)
      $display("FAIL bp_drain got v=%b r=%b exp v=0 r=1", bus4.out_valid, bus4.in_ready);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_sel_err();
    bus3.out_ready = 1'b1;
    bus3.in_valid  = 1'b1;
    bus3.mux_ctrl  = 2'd3;
    tick();
    n_total++;
    if (bus3.out_valid !== 1'b1 || bus3.choice !== 16'h0000 || bus3.sel_err !== 1'b1 || bus3.choice_sel !== 2'd3)
      $display("FAIL selerr_oor got v=%b d=%h e=%b s=%0d exp v=1 d=0000 e=1 s=3",
               bus3.out_valid, bus3.choice, bus3.sel_err, bus3.choice_sel);
    else n_pass++;
    bus3.mux_ctrl = 2'd0;
    tick();
    n_total++;
    if (bus3.choice !== 16'h1111 || bus3.sel_err !== 1'b0 || bus3.choice_sel !== 2'd0)
      $display("FAIL selerr_ch0 got d=%h e=%b s=%0d exp d=1111 e=0 s=0", bus3.choice, bus3.sel_err, bus3.choice_sel);
    else n_pass++;
    bus3.mux_ctrl = 2'd2;
    tick();
    n_total++;
    if (bus3.choice !== 16'h3333 || bus3.sel_err !== 1'b0 || bus3.choice_sel !== 2'd2)
      $display("FAIL selerr_ch2 got d=%h e=%b s=%0d exp d=3333 e=0 s=2", bus3.choice, bus3.sel_err, bus3.choice_sel);
    else n_pass++;
    bus3.in_valid = 1'b0;
    tick();
    n_total++;
    if (bus3.out_valid !== 1'b0) $display("FAIL selerr_drain got %b exp 0", bus3.out_valid);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_flush();
    // Fill to FULL, then flush with an offer pending
    bus4.in_valid = 1'b1;
    bus4.mux_ctrl = 2'd0;
    tick();
    bus4.mux_ctrl = 2'd1;
    tick();
    n_total++;
    if (bus4.in_ready !== 1'b0) $display("FAIL flush_prefill got r=%b exp 0", bus4.in_ready);
    else n_pass++;
    bus4.mux_ctrl = 2'd2;
    bus4.flush    = 1'b1;
    tick();
    n_total++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1)
      $display("FAIL flush_full got v=%b r=%b exp v=0 r=1", bus4.out_valid, bus4.in_ready);
    else n_pass++;
    bus4.flush     = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    tick();
    n_total++;
    if (bus4.out_valid !== 1'b0) $display("FAIL flush_full_after got v=%b exp 0", bus4.out_valid);
    else n_pass++;
    // Flush in ONE while in_ready=1: the offer is dropped
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 1'b1;
    bus4.mux_ctrl  = 2'd3;
    tick();
    bus4.mux_ctrl = 2'd2;
    bus4.flush    = 1'b1;
    tick();
    n_total++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1)
      $display("FAIL flush_one got v=%b r=%b exp v=0 r=1", bus4.out_valid, bus4.in_ready);
    else n_pass++;
    bus4.flush    = 1'b0;
    bus4.in_valid = 1'b0;
    tick();
    n_total++;
    if (bus4.out_valid !== 1'b0) $display("FAIL flush_one_after got v=%b exp 0", bus4.out_valid);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_async_reset();
    bus4.in_valid = 1'b1;
    bus4.mux_ctrl = 2'd3;
    tick();
    bus4.mux_ctrl = 2'd1;
    tick();
    bus4.in_valid = 1'b0;
    // Mid-cycle assert, no edge in between
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.choice !== 16'h0000 ||
        bus4.choice_sel !== 2'd0 || bus4.sel_err !== 1'b0)
      $display("FAIL async_rst got r=%b v=%b d=%h s=%0d e=%b exp r=1 v=0 d=0000 s=0 e=0",
               bus4.in_ready, bus4.out_valid, bus4.choice, bus4.choice_sel, bus4.sel_err);
    else n_pass++;
    tick();
    #2;
    rst_n = 1'b1;
    bus4.in_valid  = 1'b1;
    bus4.mux_ctrl  = 2'd2;
    bus4.out_ready = 1'b1;
    tick();
    n_total++;
    if (bus4.out_valid !== 1'b1 || bus4.choice !== 16'hCCCC || bus4.choice_sel !== 2'd2)
      $display("FAIL async_first got v=%b d=%h s=%0d exp v=1 d=cccc s=2",
               bus4.out_valid, bus4.choice, bus4.choice_sel);
    else n_pass++;
    bus4.in_valid = 1'b0;
    tick();
    n_total++;
    if (bus4.out_valid !== 1'b0) $display("FAIL async_drain got v=%b exp 0", bus4.out_valid);
    else n_pass++;
    idle_inputs();
  endtask

  initial begin
    bus4.mux_in = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    bus3.mux_in = {16'h3333, 16'h2222, 16'h1111};
    idle_inputs();
    test_reset();
    test_streaming();
    test_backpressure();
    test_sel_err();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
